// File: rtl/hartslag_pkg.sv
// Shared types and sizing for the heart-rate measurement sequencer.
package hartslag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT
  } state_e;

  localparam int unsigned COUNT_W_DEF = 8;
  localparam int unsigned WIN_W       = 28;
  localparam int unsigned AVG_DEPTH   = 4;
  localparam int unsigned AVG_SHIFT   = $clog2(AVG_DEPTH);

endpackage

// File: rtl/hartslag_beat_conditioner.sv
// Pulse-sensor conditioning: 2-flop synchroniser, debounce, rising-edge detect
// and refractory lockout; beat_acc pulses once per accepted beat.
module hartslag_beat_conditioner
  import hartslag_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 50_000,
  parameter int unsigned REFRACTORY_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic ingang,
  output logic beat_acc
);

  localparam logic [WIN_W-1:0] DB_LAST   = WIN_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] REFR_LOAD = WIN_W'(REFRACTORY_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_prev_q;
  logic             beat_q;
  logic [WIN_W-1:0] db_cnt_q;
  logic [WIN_W-1:0] refr_q;
  logic             cand_c;

  assign cand_c   = filt_q & ~filt_prev_q;
  assign beat_acc = beat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      beat_q      <= 1'b0;
      db_cnt_q    <= '0;
      refr_q      <= '0;
    end else begin
      sync1_q     <= ingang;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      // Filtered level follows only after a run of identical differing samples.
      if (sync2_q == filt_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        filt_q   <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + WIN_W'(1);
      end
      beat_q <= 1'b0;
      if (cand_c && (refr_q == '0)) begin
        beat_q <= 1'b1;
        refr_q <= REFR_LOAD;
      end else if (refr_q != '0) begin
        refr_q <= refr_q - WIN_W'(1);
      end
    end
  end

endmodule

// File: rtl/hartslag_meet_sequencer.sv
// Heart-rate window sequencer: SETTLE warm-up window, then back-to-back MEASURE
// windows each closed by a one-cycle REPORT. Define HARTSLAG_AVG_EN for a
// 4-window moving average on slagen.
module hartslag_meet_sequencer
  import hartslag_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES   = 50_000,
  parameter int unsigned REFRACTORY_CYCLES = 10_000_000,
  parameter int unsigned COUNT_W           = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               ingang,
  output logic [COUNT_W-1:0] slagen,
  output logic               valid,
  output logic               window_tick,
  output logic               busy,
  output logic               overflow
);

  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

  state_e             state_q;
  logic [WIN_W-1:0]   win_q;
  logic [COUNT_W-1:0] beat_cnt_q;
  logic [COUNT_W-1:0] slagen_q;
  logic               valid_q, window_tick_q, busy_q, overflow_q;

  logic               beat_acc;
  logic               win_end_c;
  logic [WIN_W-1:0]   win_nxt_c;
  logic               cnt_sat_c;
  logic [COUNT_W-1:0] cnt_inc_c;
  logic               ovf_hit_c;
  logic               start_c;
  logic               report_c;
  logic [COUNT_W-1:0] rep_c;

  hartslag_beat_conditioner #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .REFRACTORY_CYCLES(REFRACTORY_CYCLES)
  ) u_cond (
    .clk     (clk),
    .reset   (reset),
    .ingang  (ingang),
    .beat_acc(beat_acc)
  );

  assign win_end_c = (win_q == WIN_LAST);
  assign win_nxt_c = win_end_c ? '0 : win_q + WIN_W'(1);
  assign cnt_sat_c = (beat_cnt_q == CNT_MAX);
  assign cnt_inc_c = (beat_acc && !cnt_sat_c) ? beat_cnt_q + COUNT_W'(1) : beat_cnt_q;
  assign ovf_hit_c = beat_acc && cnt_sat_c;
  assign start_c   = (state_q == IDLE) && start && !stop;
  assign report_c  = (state_q == MEASURE) && win_end_c && !stop;

`ifdef HARTSLAG_AVG_EN
  localparam int unsigned SUM_W = COUNT_W + AVG_SHIFT;

  logic [COUNT_W-1:0] hist_q [AVG_DEPTH];
  logic [SUM_W-1:0]   sum_q;
  logic [SUM_W-1:0]   sum_nxt_c;
  logic               avg_first_q;

  // First report after start seeds every history slot with the same count.
  always_comb begin
    sum_nxt_c = sum_q - SUM_W'(hist_q[AVG_DEPTH-1]) + SUM_W'(cnt_inc_c);
    if (avg_first_q) sum_nxt_c = SUM_W'(cnt_inc_c) << AVG_SHIFT;
  end

  assign rep_c = COUNT_W'(sum_nxt_c >> AVG_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(AVG_DEPTH); i++) hist_q[i] <= '0;
      sum_q       <= '0;
      avg_first_q <= 1'b0;
    end else if (start_c) begin
      avg_first_q <= 1'b1;
    end else if (report_c) begin
      avg_first_q <= 1'b0;
      sum_q       <= sum_nxt_c;
      hist_q[0]   <= cnt_inc_c;
      for (int i = 1; i < int'(AVG_DEPTH); i++)
        hist_q[i] <= avg_first_q ? cnt_inc_c : hist_q[i-1];
    end
  end
`else
  assign rep_c = cnt_inc_c;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= '0;
      beat_cnt_q    <= '0;
      slagen_q      <= '0;
      valid_q       <= 1'b0;
      window_tick_q <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      valid_q       <= 1'b0;
      window_tick_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_c) begin
          state_q    <= SETTLE;
          win_q      <= '0;
          beat_cnt_q <= '0;
          overflow_q <= 1'b0;
          busy_q     <= 1'b1;
        end
      end else if (stop) begin
        state_q    <= IDLE;
        win_q      <= '0;
        beat_cnt_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        win_q         <= win_nxt_c;
        window_tick_q <= (win_nxt_c == WIN_LAST);
        if (state_q == SETTLE) begin
          if (win_end_c) state_q <= MEASURE;
        end else begin
          // MEASURE or REPORT: REPORT is cycle 0 of the next window and counts beats.
          if (ovf_hit_c) overflow_q <= 1'b1;
          if (report_c) begin
            state_q    <= REPORT;
            slagen_q   <= rep_c;
            valid_q    <= 1'b1;
            beat_cnt_q <= '0;
          end else begin
            state_q    <= MEASURE;
            beat_cnt_q <= cnt_inc_c;
          end
        end
      end
    end
  end

  assign slagen      = slagen_q;
  assign valid       = valid_q;
  assign window_tick = window_tick_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_hartslag_meet_sequencer.sv
// Directed bench for hartslag_meet_sequencer (short windows, fast debounce).
module tb_hartslag_meet_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, ingang;
  logic [7:0] slagen;
  logic       valid, window_tick, busy, overflow;

  logic       start2, stop2, ingang2;
  logic [7:0] slagen2;
  logic       valid2, window_tick2, busy2, overflow2;

  int checks = 0;
  int passed = 0;

  int m_hist [4];
  bit m_first;

  hartslag_meet_sequencer #(
    .WINDOW_CYCLES(100), .DEBOUNCE_CYCLES(2), .REFRACTORY_CYCLES(5), .COUNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ingang(ingang),
    .slagen(slagen), .valid(valid), .window_tick(window_tick), .busy(busy),
    .overflow(overflow)
  );

  hartslag_meet_sequencer #(
    .WINDOW_CYCLES(4000), .DEBOUNCE_CYCLES(2), .REFRACTORY_CYCLES(1), .COUNT_W(8)
  ) dut_ovf (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2), .ingang(ingang2),
    .slagen(slagen2), .valid(valid2), .window_tick(window_tick2), .busy(busy2),
    .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected slagen for a window whose raw beat count is raw.
  function automatic int exp_out(input int raw);
`ifdef HARTSLAG_AVG_EN
    int s;
    if (m_first) begin
      for (int i = 0; i < 4; i++) m_hist[i] = raw;
    end else begin
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = raw;
    end
    m_first = 1'b0;
    s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
    return s / 4;
`else
    return raw;
`endif
  endfunction

  function automatic logic [99:0] pulses(input int n, input int half, input int first);
    logic [99:0] p;
    p = '0;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < half; j++) p[first + k*2*half + j] = 1'b1;
    return p;
  endfunction

  // Drives one 100-cycle window from its cycle 0; ends on the next window's cycle 0.
  task automatic run_window(input logic [99:0] pat, output int tick_err, output int valid_seen);
    tick_err   = 0;
    valid_seen = 0;
    for (int off = 0; off < 100; off++) begin
      if (window_tick !== (off == 99)) tick_err++;
      if (off > 0 && valid === 1'b1) valid_seen++;
      ingang = pat[off];
      step();
    end
    ingang = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start   = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; ingang = 0; start2 = 0; stop2 = 0; ingang2 = 0;
    step();
    checks++; if ({slagen, valid, window_tick, busy, overflow} !== 12'h0)
      $display("FAIL reset_outputs got %h want 0", {slagen, valid, window_tick, busy, overflow});
    else passed++;
    checks++; if ({slagen2, valid2, busy2, overflow2} !== 11'h0)
      $display("FAIL reset_outputs2 got %h want 0", {slagen2, valid2, busy2, overflow2});
    else passed++;
    reset = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_measure();
    int te, vs, e;
    do_start();
    checks++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else passed++;
    run_window(pulses(3, 5, 5), te, vs);
    checks++; if (te !== 0) $display("FAIL settle_tick errors %0d want 0", te); else passed++;
    checks++; if (vs !== 0) $display("FAIL settle_valid got %0d strobes want 0", vs); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL settle_end_valid got %b want 0", valid); else passed++;
    run_window(pulses(7, 5, 5), te, vs);
    checks++; if (te !== 0) $display("FAIL measure_tick errors %0d want 0", te); else passed++;
    checks++; if (vs !== 0) $display("FAIL measure_early_valid got %0d want 0", vs); else passed++;
    e = exp_out(7);
    checks++; if (valid !== 1'b1) $display("FAIL m1_valid got %b want 1", valid); else passed++;
    checks++; if (slagen !== 8'(e)) $display("FAIL m1_slagen got %0d want %0d", slagen, e); else passed++;
  endtask

  task automatic test_glitch();
    int te, vs, e;
    logic [99:0] p;
    p = '0;
    p[5] = 1'b1; p[10] = 1'b1; p[15] = 1'b1;
    p[30] = 1'b1; p[32] = 1'b1;
    for (int i = 34; i <= 44; i++) p[i] = 1'b1;
    p[46] = 1'b1;
    run_window(p, te, vs);
    e = exp_out(1);
    checks++; if (valid !== 1'b1) $display("FAIL glitch_valid got %b want 1", valid); else passed++;
    checks++; if (slagen !== 8'(e)) $display("FAIL glitch_slagen got %0d want %0d", slagen, e); else passed++;
  endtask

  task automatic test_refractory();
    int te, vs, e;
    logic [99:0] p;
    p = '0;
    p[10] = 1'b1; p[11] = 1'b1;
    for (int i = 14; i <= 19; i++) p[i] = 1'b1;
    run_window(p, te, vs);
    e = exp_out(1);
    checks++; if (slagen !== 8'(e)) $display("FAIL refractory_slagen got %0d want %0d", slagen, e); else passed++;
  endtask

  task automatic test_stop();
    int te, vs, e, vcnt, tcnt;
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL stop_busy got %b want 0", busy); else passed++;
    do_start();
    run_window('0, te, vs);
    run_window(pulses(3, 5, 5), te, vs);
    e = exp_out(3);
    checks++; if (slagen !== 8'(e) || valid !== 1'b1)
      $display("FAIL stop_first_report got %0d/%b want %0d/1", slagen, valid, e);
    else passed++;
    for (int off = 0; off < 50; off++) begin
      ingang = (off >= 5 && off < 30 && ((off - 5) % 10) < 5);
      step();
    end
    ingang = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL stop_idle busy/valid got %b/%b want 0/0", busy, valid);
    else passed++;
    vcnt = 0; tcnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (valid === 1'b1) vcnt++;
      if (window_tick === 1'b1) tcnt++;
      step();
    end
    checks++; if (vcnt !== 0 || tcnt !== 0)
      $display("FAIL stop_quiet got valid %0d tick %0d want 0 0", vcnt, tcnt);
    else passed++;
    checks++; if (slagen !== 8'(e)) $display("FAIL stop_hold_slagen got %0d want %0d", slagen, e); else passed++;
  endtask

  task automatic test_start_stop_together();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL start_stop_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_average();
    int te, vs, e;
    int counts [4] = '{8, 4, 4, 12};
    do_start();
    run_window('0, te, vs);
    for (int w = 0; w < 4; w++) begin
      run_window(pulses(counts[w], 3, 5), te, vs);
      e = exp_out(counts[w]);
      checks++; if (valid !== 1'b1 || slagen !== 8'(e))
        $display("FAIL avg_window%0d got %0d/%b want %0d/1", w, slagen, valid, e);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if ({slagen, valid, busy} !== 10'h0)
      $display("FAIL async_reset got slagen %0d valid %b busy %b want 0", slagen, valid, busy);
    else passed++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    int e1, e2;
`ifdef HARTSLAG_AVG_EN
    e1 = 255; e2 = 191;
`else
    e1 = 255; e2 = 0;
`endif
    start2 = 1'b1; step(); start2 = 1'b0;
    repeat (4000) step();
    for (int off = 0; off < 4000; off++) begin
      ingang2 = (off >= 5 && off < 1805 && ((off - 5) % 6) < 3);
      step();
    end
    ingang2 = 1'b0;
    checks++; if (valid2 !== 1'b1 || slagen2 !== 8'(e1))
      $display("FAIL ovf_report got %0d/%b want %0d/1", slagen2, valid2, e1);
    else passed++;
    checks++; if (overflow2 !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow2); else passed++;
    repeat (4000) step();
    checks++; if (valid2 !== 1'b1 || slagen2 !== 8'(e2))
      $display("FAIL ovf_next_report got %0d/%b want %0d/1", slagen2, valid2, e2);
    else passed++;
    checks++; if (overflow2 !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow2); else passed++;
    stop2 = 1'b1; step(); stop2 = 1'b0;
    checks++; if (busy2 !== 1'b0 || overflow2 !== 1'b1)
      $display("FAIL ovf_after_stop busy/ovf got %b/%b want 0/1", busy2, overflow2);
    else passed++;
    start2 = 1'b1; step(); start2 = 1'b0;
    checks++; if (overflow2 !== 1'b0 || busy2 !== 1'b1)
      $display("FAIL ovf_clear busy/ovf got %b/%b want 1/0", busy2, overflow2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_measure();
    test_glitch();
    test_refractory();
    test_stop();
    test_start_stop_together();
    test_average();
    test_async_reset();
    test_overflow();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
